// File: rtl/pwm_seq_pkg.sv
// ---------------------------------------------------------------------------
// pwm_seq_pkg
// Shared types and constants for the PWM tone sequencer.
//   - seq_state_e : sequencer FSM states (ST_GAP used only when PWM_SEQ_GAP_EN
//                   is defined)
//   - note entry layout: {dur[DUR_W-1:0], note_hz[HZ_W-1:0]}
//   - entry_hz / entry_dur : field extraction helpers
// ---------------------------------------------------------------------------
package pwm_seq_pkg;

  localparam int DUR_W   = 4;
  localparam int HZ_W    = 16;
  localparam int ENTRY_W = DUR_W + HZ_W;
  localparam int HZ_LSB  = 0;
  localparam int DUR_LSB = HZ_W;
  localparam int DUTY_W  = 10;
  localparam int FREQ_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  function automatic logic [HZ_W-1:0] entry_hz(input logic [ENTRY_W-1:0] e);
    return e[HZ_LSB +: HZ_W];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/pwm_tone_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_tone_sequencer_if
// Control/config bundle between the top-level controller (master) and the
// tone sequencer (slave).
//   master drives : wr_en, wr_addr, wr_data, len, loop, volume, start, stop
//   slave drives  : freq, duty, busy, done, note_idx
// Parameter AW must equal $clog2(DEPTH) of the attached sequencer.
// ---------------------------------------------------------------------------
interface pwm_tone_sequencer_if #(
  parameter int AW = 5
) ();
  import pwm_seq_pkg::*;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [AW:0]        len;
  logic               loop;
  logic [DUTY_W-1:0]  volume;
  logic               start;
  logic               stop;
  logic [FREQ_W-1:0]  freq;
  logic [DUTY_W-1:0]  duty;
  logic               busy;
  logic               done;
  logic [AW-1:0]      note_idx;

  modport master (
    output wr_en, wr_addr, wr_data, len, loop, volume, start, stop,
    input  freq, duty, busy, done, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, loop, volume, start, stop,
    output freq, duty, busy, done, note_idx
  );
endinterface

// File: rtl/pwm_seq_ram.sv
// ---------------------------------------------------------------------------
// pwm_seq_ram
// DEPTH x WIDTH note storage: one synchronous write port, one registered read
// port. Contents are not reset.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address, sampled every clock
//   rd_data_o  : registered read data (old data on same-address write)
// ---------------------------------------------------------------------------
module pwm_seq_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pwm_tone_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_tone_sequencer
// Plays a stored note list by driving the freq/duty inputs of a PWM generator.
// Each entry {dur, note_hz} sounds for (dur+1) beats; note_hz==0 is a rest.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : pwm_tone_sequencer_if.slave
//          in : wr_en/wr_addr/wr_data (note RAM write), len, loop, volume,
//               start, stop
//          out: freq (never 0), duty, busy, done (1-cycle), note_idx
// Optional feature macro: PWM_SEQ_GAP_EN -- inserts GAP_CYCLES of silence
// between consecutive notes (including the loop wrap).
// ---------------------------------------------------------------------------
module pwm_tone_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEPTH       = 32,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int IDLE_FREQ   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  pwm_tone_sequencer_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int BC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  // CLK_HZ only documents beat sizing; GAP_CYCLES is idle without the macro.
  logic unused_cfg;
  assign unused_cfg = (CLK_HZ > 0) ^ (GAP_CYCLES > 0);

  seq_state_e         state_q, state_d;
  logic [AW-1:0]      note_idx_q, note_idx_d;
  logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic               done_q, done_d;

`ifdef PWM_SEQ_GAP_EN
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam seq_state_e BETWEEN_ST = ST_GAP;
  logic [GC_W-1:0]    gap_cnt_q, gap_cnt_d;
`else
  localparam seq_state_e BETWEEN_ST = ST_FETCH;
`endif

  logic [ENTRY_W-1:0] rd_data;
  logic [HZ_W-1:0]    rd_hz;
  logic [AW:0]        eff_len;
  logic               last_entry;
  logic               beat_end;

  // The read port follows the next index so that the entry is already
  // registered when FETCH is entered; FETCH then only latches it.
  pwm_seq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (note_idx_d),
    .rd_data_o (rd_data)
  );

  assign rd_hz      = entry_hz(rd_data);
  assign eff_len    = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
  assign last_entry = ({1'b0, note_idx_q} == (eff_len - (AW+1)'(1)));
  assign beat_end   = (beat_cnt_q == BC_W'(BEAT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    beat_cnt_d = beat_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    cur_dur_d  = cur_dur_q;
    freq_d     = freq_q;
    duty_d     = '0;
    done_d     = 1'b0;
`ifdef PWM_SEQ_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop && (eff_len != '0)) begin
          state_d    = ST_FETCH;
          note_idx_d = '0;
        end
      end

      ST_FETCH: begin
        state_d    = ST_PLAY;
        beat_cnt_d = '0;
        dur_cnt_d  = '0;
        cur_dur_d  = entry_dur(rd_data);
        if (rd_hz != '0) begin
          freq_d = FREQ_W'(rd_hz);
          duty_d = bus.volume;
        end
      end

      ST_PLAY: begin
        duty_d     = duty_q;
        beat_cnt_d = beat_cnt_q + BC_W'(1);
        if (beat_end) begin
          beat_cnt_d = '0;
          dur_cnt_d  = dur_cnt_q + DUR_W'(1);
          if (dur_cnt_q == cur_dur_q) begin
            dur_cnt_d = '0;
            duty_d    = '0;
            if (!last_entry) begin
              note_idx_d = note_idx_q + AW'(1);
              state_d    = BETWEEN_ST;
            end else if (bus.loop) begin
              note_idx_d = '0;
              state_d    = BETWEEN_ST;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

`ifdef PWM_SEQ_GAP_EN
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GC_W'(1);
        if (gap_cnt_q == GC_W'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_FETCH;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Abort from any busy state; no done pulse, freq holds.
    if (bus.stop && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      note_idx_d = '0;
      beat_cnt_d = '0;
      dur_cnt_d  = '0;
      duty_d     = '0;
      done_d     = 1'b0;
`ifdef PWM_SEQ_GAP_EN
      gap_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      note_idx_q <= '0;
      beat_cnt_q <= '0;
      dur_cnt_q  <= '0;
      cur_dur_q  <= '0;
      freq_q     <= FREQ_W'(IDLE_FREQ);
      duty_q     <= '0;
      done_q     <= 1'b0;
`ifdef PWM_SEQ_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      beat_cnt_q <= beat_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      cur_dur_q  <= cur_dur_d;
      freq_q     <= freq_d;
      duty_q     <= duty_d;
      done_q     <= done_d;
`ifdef PWM_SEQ_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign bus.freq     = freq_q;
  assign bus.duty     = duty_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = note_idx_q;

endmodule
